thread_register_file: RTL and testbench

//  Per-core register file serving all thread lanes of a block: NUM_REGS x DATA_BITS registers per lane.
//  The top 3 registers of each lane are read-only (%blockIdx, %blockDim, %threadIdx).

---
 rtl/thread_register_file.sv | 161 ++++++++++++++++
 tb/tb_thread_register_file.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/thread_register_file.sv
// thread_register_file
// Per-core register file shared by all thread lanes. Each lane owns NUM_REGS
// registers of DATA_BITS; the top three (%blockIdx, %blockDim, %threadIdx)
// are read-only. Operands are captured in REQUEST and rd is written in UPDATE.
// Optional feature macro: TRF_ZERO_REG_EN (R0 hard-wired to zero when defined).
module thread_register_file #(
  parameter int DATA_BITS = 8,
  parameter int NUM_REGS  = 16,
  parameter int THREADS   = 4,
  localparam int ADDR_BITS = $clog2(NUM_REGS),
  localparam int CNT_BITS  = $clog2(THREADS) + 1,
  localparam int RO_BASE   = NUM_REGS - 3
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           block_start,
  input  logic [DATA_BITS-1:0]           block_id,
  input  logic [CNT_BITS-1:0]            thread_count,
  input  logic [2:0]                     core_state,
  input  logic [ADDR_BITS-1:0]           decoded_rd_address,
  input  logic [ADDR_BITS-1:0]           decoded_rs_address,
  input  logic [ADDR_BITS-1:0]           decoded_rt_address,
  input  logic                           decoded_reg_write_enable,
  input  logic [1:0]                     decoded_reg_input_mux,
  input  logic [DATA_BITS-1:0]           decoded_immediate,
  input  logic [THREADS*DATA_BITS-1:0]   alu_out,
  input  logic [THREADS*DATA_BITS-1:0]   lsu_out,
  output logic [THREADS*DATA_BITS-1:0]   rs,
  output logic [THREADS*DATA_BITS-1:0]   rt,
  output logic                           operands_valid,
  output logic                           ro_write_error
);

  localparam logic [2:0] ST_REQUEST = 3'b011;
  localparam logic [2:0] ST_UPDATE  = 3'b110;
  localparam logic [1:0] MUX_ALU    = 2'b00;
  localparam logic [1:0] MUX_LSU    = 2'b01;
  localparam logic [1:0] MUX_IMM    = 2'b10;

  // Block-wide state shared by every lane
  logic [DATA_BITS-1:0] r_block_id;
  logic [DATA_BITS-1:0] r_block_dim;
  logic [CNT_BITS-1:0]  r_active_cnt;

  logic                 w_request;
  logic                 w_update;
  logic                 w_rd_illegal;
  logic                 w_zero_drop;
  logic                 w_do_write;
  logic                 w_set_error;
  logic [CNT_BITS-1:0]  w_cnt_sat;

  assign w_request = (core_state == ST_REQUEST);
  assign w_update  = (core_state == ST_UPDATE);

  // Writes into the read-only window or with the reserved mux code are refused
  assign w_rd_illegal = (decoded_rd_address >= ADDR_BITS'(RO_BASE)) ||
                        (decoded_reg_input_mux == 2'b11);

`ifdef TRF_ZERO_REG_EN
  assign w_zero_drop = (decoded_rd_address == '0);
`else
  assign w_zero_drop = 1'b0;
`endif

  // block_start has priority over an UPDATE on the same edge: write and error are both dropped
  assign w_do_write  = w_update && decoded_reg_write_enable && !block_start &&
                       !w_rd_illegal && !w_zero_drop;
  assign w_set_error = w_update && decoded_reg_write_enable && !block_start && w_rd_illegal;

  assign w_cnt_sat = (thread_count > CNT_BITS'(THREADS)) ? CNT_BITS'(THREADS) : thread_count;

  // Resolve an architectural register read for one lane, overlaying the read-only window
  function automatic logic [DATA_BITS-1:0] f_read(
    input logic [ADDR_BITS-1:0] addr,
    input logic [DATA_BITS-1:0] gpr_val,
    input int                   lane
  );
    logic [DATA_BITS-1:0] v;
    if (addr == ADDR_BITS'(RO_BASE))          v = r_block_id;
    else if (addr == ADDR_BITS'(RO_BASE + 1)) v = r_block_dim;
    else if (addr == ADDR_BITS'(RO_BASE + 2)) v = DATA_BITS'(lane);
`ifdef TRF_ZERO_REG_EN
    else if (addr == '0)                      v = '0;
`endif
    else                                      v = gpr_val;
    return v;
  endfunction

  // Block launch latching, operand strobe and sticky error flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_block_id     <= '0;
      r_block_dim    <= DATA_BITS'(THREADS);
      r_active_cnt   <= CNT_BITS'(THREADS);
      operands_valid <= 1'b0;
      ro_write_error <= 1'b0;
    end else begin
      operands_valid <= w_request;
      if (block_start) begin
        r_block_id     <= block_id;
        r_block_dim    <= DATA_BITS'(w_cnt_sat);
        r_active_cnt   <= w_cnt_sat;
        ro_write_error <= 1'b0;
      end else if (w_set_error) begin
        ro_write_error <= 1'b1;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < THREADS; gi++) begin : g_lane
      logic [DATA_BITS-1:0] r_regs [NUM_REGS];
      logic [DATA_BITS-1:0] r_rs;
      logic [DATA_BITS-1:0] r_rt;
      logic [DATA_BITS-1:0] w_rs_val;
      logic [DATA_BITS-1:0] w_rt_val;
      logic [DATA_BITS-1:0] w_wr_data;
      logic                 w_lane_active;

      assign w_lane_active = (CNT_BITS'(gi) < r_active_cnt);
      assign w_rs_val = f_read(decoded_rs_address, r_regs[decoded_rs_address], gi);
      assign w_rt_val = f_read(decoded_rt_address, r_regs[decoded_rt_address], gi);

      // Select this lane's writeback source; immediate is broadcast to every lane
      always_comb begin
        w_wr_data = decoded_immediate;
        case (decoded_reg_input_mux)
          MUX_ALU: w_wr_data = alu_out[gi*DATA_BITS +: DATA_BITS];
          MUX_LSU: w_wr_data = lsu_out[gi*DATA_BITS +: DATA_BITS];
          MUX_IMM: w_wr_data = decoded_immediate;
          default: w_wr_data = decoded_immediate;
        endcase
      end

      // Lane storage and operand capture; reads see pre-clear values when block_start coincides
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
          r_rs <= '0;
          r_rt <= '0;
        end else begin
          if (w_request && w_lane_active) begin
            r_rs <= w_rs_val;
            r_rt <= w_rt_val;
          end
          if (block_start) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
          end else if (w_do_write && w_lane_active) begin
            r_regs[decoded_rd_address] <= w_wr_data;
          end
        end
      end

      assign rs[gi*DATA_BITS +: DATA_BITS] = r_rs;
      assign rt[gi*DATA_BITS +: DATA_BITS] = r_rt;
    end
  endgenerate

endmodule

// File: tb/tb_thread_register_file.sv
// Testbench for thread_register_file: directed scenarios followed by random
// traffic, all compared against an architectural model of the register file.
module tb_thread_register_file;
  localparam int DB = 8;
  localparam int NR = 16;
  localparam int TH = 4;
  localparam int AB = $clog2(NR);
  localparam int CB = $clog2(TH) + 1;
  localparam int RO = NR - 3;

  logic              clk;
  logic              reset;
  logic              block_start;
  logic [DB-1:0]     block_id;
  logic [CB-1:0]     thread_count;
  logic [2:0]        core_state;
  logic [AB-1:0]     rd_a, rs_a, rt_a;
  logic              we;
  logic [1:0]        mux;
  logic [DB-1:0]     imm;
  logic [TH*DB-1:0]  alu_out, lsu_out;
  logic [TH*DB-1:0]  rs, rt;
  logic              operands_valid;
  logic              ro_write_error;

  int n_checks = 0;
  int n_errors = 0;

  // Architectural model
  int m_gpr [TH][NR];
  int m_bid, m_dim, m_cnt, m_err, m_valid;
  int m_rs [TH];
  int m_rt [TH];

  thread_register_file #(.DATA_BITS(DB), .NUM_REGS(NR), .THREADS(TH)) dut (
    .clk(clk), .reset(reset), .block_start(block_start), .block_id(block_id),
    .thread_count(thread_count), .core_state(core_state),
    .decoded_rd_address(rd_a), .decoded_rs_address(rs_a), .decoded_rt_address(rt_a),
    .decoded_reg_write_enable(we), .decoded_reg_input_mux(mux),
    .decoded_immediate(imm), .alu_out(alu_out), .lsu_out(lsu_out),
    .rs(rs), .rt(rt), .operands_valid(operands_valid), .ro_write_error(ro_write_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int m_read(int t, int a);
    if (a == NR - 1) return t;
    if (a == NR - 2) return m_dim;
    if (a == NR - 3) return m_bid;
`ifdef TRF_ZERO_REG_EN
    if (a == 0) return 0;
`endif
    return m_gpr[t][a];
  endfunction

  task automatic model_reset();
    for (int t = 0; t < TH; t++) begin
      for (int a = 0; a < NR; a++) m_gpr[t][a] = 0;
      m_rs[t] = 0;
      m_rt[t] = 0;
    end
    m_bid = 0; m_dim = TH; m_cnt = TH; m_err = 0; m_valid = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    for (int t = 0; t < TH; t++) begin
      chk($sformatf("%s rs[%0d]", tag, t), 32'(rs[t*DB +: DB]), 32'(m_rs[t]));
      chk($sformatf("%s rt[%0d]", tag, t), 32'(rt[t*DB +: DB]), 32'(m_rt[t]));
    end
    chk({tag, " operands_valid"}, 32'(operands_valid), 32'(m_valid));
    chk({tag, " ro_write_error"}, 32'(ro_write_error), 32'(m_err));
  endtask

  // Apply one clock edge to the model from the current inputs, then compare
  task automatic cycle(input string tag);
    int c;
    if (core_state == 3'b011) begin
      for (int t = 0; t < m_cnt; t++) begin
        m_rs[t] = m_read(t, int'(rs_a));
        m_rt[t] = m_read(t, int'(rt_a));
      end
    end
    if (block_start) begin
      for (int t = 0; t < TH; t++)
        for (int a = 0; a < NR; a++) m_gpr[t][a] = 0;
      c = (int'(thread_count) > TH) ? TH : int'(thread_count);
      m_bid = int'(block_id); m_dim = c; m_cnt = c; m_err = 0;
    end else if (core_state == 3'b110 && we) begin
      if (int'(rd_a) >= RO || mux == 2'b11) m_err = 1;
`ifdef TRF_ZERO_REG_EN
      else if (rd_a == 0) ;
`endif
      else begin
        for (int t = 0; t < m_cnt; t++)
          m_gpr[t][rd_a] = (mux == 2'b00) ? int'(alu_out[t*DB +: DB]) :
                           (mux == 2'b01) ? int'(lsu_out[t*DB +: DB]) : int'(imm);
      end
    end
    m_valid = (core_state == 3'b011) ? 1 : 0;
    @(posedge clk);
    #1;
    check_all(tag);
    $display("cycle %s: state=%0d bs=%0d rs_a=%0d rt_a=%0d rd_a=%0d we=%0d mux=%0d rs=%h rt=%h v=%0d err=%0d",
             tag, core_state, block_start, rs_a, rt_a, rd_a, we, mux, rs, rt,
             operands_valid, ro_write_error);
  endtask

  task automatic set_idle();
    block_start = 0; core_state = 3'b000; we = 0; mux = 2'b00;
    rd_a = '0; rs_a = '0; rt_a = '0; imm = '0;
  endtask

  task automatic req(input int a, input int b, input string tag);
    set_idle(); core_state = 3'b011; rs_a = AB'(a); rt_a = AB'(b);
    cycle(tag);
    set_idle();
    cycle({tag, " idle"});
  endtask

  task automatic upd(input logic w, input int rd, input logic [1:0] m, input int im, input string tag);
    set_idle(); core_state = 3'b110; we = w; rd_a = AB'(rd); mux = m; imm = DB'(im);
    cycle(tag);
    set_idle();
  endtask

  task automatic blk(input int id, input int cnt, input string tag);
    set_idle(); block_start = 1; block_id = DB'(id); thread_count = CB'(cnt);
    cycle(tag);
    set_idle();
  endtask

  int idle_states [6] = '{0, 1, 2, 4, 5, 7};
  int op;

  initial begin
    reset = 0;
    block_id = '0; thread_count = '0;
    alu_out = '0; lsu_out = '0;
    set_idle();
    model_reset();
    #2;
    check_all("reset");
    @(posedge clk); #1;
    reset = 1;

    // Scenario 1: reset asserted in the middle of an UPDATE
    upd(1, 14, 2'b00, 0, "ro write pre-reset");
    req(13, 15, "pre-reset req");
    set_idle(); core_state = 3'b110; we = 1; rd_a = 4'd3; mux = 2'b10; imm = 8'h99;
    #2;
    reset = 0;
    #1;
    model_reset();
    check_all("async reset");
    @(posedge clk); #1;
    reset = 1;
    set_idle();
    req(15, 14, "post-reset req");
    chk("lane2 threadIdx", 32'(rs[2*DB +: DB]), 32'd2);
    chk("lane2 blockDim", 32'(rt[2*DB +: DB]), 32'd4);

    // Scenario 2: block launch with 3 lanes, lane 3 holds
    blk(8'h2A, 3, "blk 2A/3");
    req(13, 14, "req ro");
    chk("lane0 blockIdx", 32'(rs[0 +: DB]), 32'h2A);
    chk("lane1 blockDim", 32'(rt[1*DB +: DB]), 32'd3);
    chk("lane3 rs hold", 32'(rs[3*DB +: DB]), 32'd3);
    chk("lane3 rt hold", 32'(rt[3*DB +: DB]), 32'd4);

    // Scenario 3: CONST and ALU writebacks with all lanes
    blk(8'h2A, 4, "blk 2A/4");
    upd(1, 5, 2'b10, 8'h7F, "const r5");
    for (int t = 0; t < TH; t++) alu_out[t*DB +: DB] = DB'(t * 10);
    upd(1, 6, 2'b00, 0, "alu r6");
    for (int t = 0; t < TH; t++) lsu_out[t*DB +: DB] = DB'(8'hA0 + t);
    upd(1, 7, 2'b01, 0, "lsu r7");
    req(5, 6, "read r5 r6");
    for (int t = 0; t < TH; t++) begin
      chk($sformatf("R5 lane%0d", t), 32'(rs[t*DB +: DB]), 32'h7F);
      chk($sformatf("R6 lane%0d", t), 32'(rt[t*DB +: DB]), 32'(t * 10));
    end
    req(7, 7, "read r7");

    // Scenario 4: read-only write is refused and the flag is sticky
    upd(1, 14, 2'b10, 8'h11, "write r14");
    chk("err after ro write", 32'(ro_write_error), 32'd1);
    req(14, 13, "read r14");
    chk("R14 unchanged", 32'(rs[1*DB +: DB]), 32'd4);
    upd(1, 2, 2'b11, 8'h22, "mux 11");
    upd(0, 15, 2'b10, 8'h22, "we=0 r15");
    chk("err still set", 32'(ro_write_error), 32'd1);

    // Scenario 5: block_start beats a coincident UPDATE
    upd(1, 1, 2'b10, 8'h33, "r1=33");
    set_idle(); block_start = 1; block_id = 8'h10; thread_count = CB'(4);
    core_state = 3'b110; we = 1; rd_a = 4'd1; mux = 2'b10; imm = 8'h55;
    cycle("blk+update");
    set_idle();
    chk("err cleared", 32'(ro_write_error), 32'd0);
    req(1, 13, "read r1");
    chk("R1 cleared", 32'(rs[0 +: DB]), 32'd0);

    // block_start coincident with REQUEST reads pre-clear values
    upd(1, 2, 2'b10, 8'h44, "r2=44");
    set_idle(); block_start = 1; block_id = 8'h77; thread_count = CB'(7);
    core_state = 3'b011; rs_a = 4'd2; rt_a = 4'd13;
    cycle("blk+request");
    set_idle();
    chk("pre-clear read", 32'(rs[3*DB +: DB]), 32'h44);
    chk("pre-clear blockIdx", 32'(rt[3*DB +: DB]), 32'h10);
    req(14, 13, "saturated dim");
    chk("dim saturated", 32'(rs[0 +: DB]), 32'd4);

    // Scenario 6: R0 behaviour depends on the zero-register option
    upd(1, 0, 2'b10, 8'h05, "const r0");
    req(0, 0, "read r0");
`ifdef TRF_ZERO_REG_EN
    chk("R0 zero", 32'(rs[0 +: DB]), 32'd0);
`else
    chk("R0 written", 32'(rs[0 +: DB]), 32'd5);
`endif
    chk("R0 no error", 32'(ro_write_error), 32'd0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      set_idle();
      op = $urandom_range(0, 9);
      rs_a = AB'($urandom); rt_a = AB'($urandom); rd_a = AB'($urandom);
      we = 1'($urandom); mux = 2'($urandom); imm = DB'($urandom);
      alu_out = (TH*DB)'({$urandom, $urandom});
      lsu_out = (TH*DB)'({$urandom, $urandom});
      if (op == 0) begin
        block_start = 1; block_id = DB'($urandom);
        thread_count = CB'($urandom_range(1, 7));
        core_state = 3'($urandom);
      end else if (op <= 3) begin
        core_state = 3'b011;
      end else if (op <= 6) begin
        core_state = 3'b110;
        if ($urandom_range(0, 3) != 0) begin
          rd_a = AB'($urandom_range(0, RO - 1));
          mux = 2'($urandom_range(0, 2));
        end
      end else begin
        core_state = 3'(idle_states[$urandom_range(0, 5)]);
      end
      cycle($sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
